// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : Multi-port architectural register file with per-register busy
//            bit and ROB rename tag; intra-group issue forwarding and commit
//            bypass on the combinational read path.
// Revision : 1.0
// ============================================================================
module reg_file_mp #(
    parameter int XLEN         = 32,
    parameter int REG_NUM      = 32,
    parameter int REG_ID_W     = 5,
    parameter int ROB_ID_W     = 4,
    parameter int ISSUE_LANES  = 2,
    parameter int COMMIT_LANES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rdy,
    input  logic                             flush,
    input  logic [ISSUE_LANES-1:0]           issue_valid,
    input  logic [ISSUE_LANES*REG_ID_W-1:0]  issue_rs1,
    input  logic [ISSUE_LANES*REG_ID_W-1:0]  issue_rs2,
    input  logic [ISSUE_LANES*REG_ID_W-1:0]  issue_rd,
    input  logic [ISSUE_LANES*ROB_ID_W-1:0]  issue_dest,
    output logic [ISSUE_LANES*XLEN-1:0]      vj_out,
    output logic [ISSUE_LANES*ROB_ID_W-1:0]  qj_out,
    output logic [ISSUE_LANES-1:0]           qj_busy,
    output logic [ISSUE_LANES*XLEN-1:0]      vk_out,
    output logic [ISSUE_LANES*ROB_ID_W-1:0]  qk_out,
    output logic [ISSUE_LANES-1:0]           qk_busy,
    input  logic [COMMIT_LANES-1:0]          commit_valid,
    input  logic [COMMIT_LANES*REG_ID_W-1:0] commit_rd,
    input  logic [COMMIT_LANES*ROB_ID_W-1:0] commit_dest,
    input  logic [COMMIT_LANES*XLEN-1:0]     commit_value
);

    logic [REG_ID_W-1:0] w_issue_rs1   [ISSUE_LANES];
    logic [REG_ID_W-1:0] w_issue_rs2   [ISSUE_LANES];
    logic [REG_ID_W-1:0] w_issue_rd    [ISSUE_LANES];
    logic [ROB_ID_W-1:0] w_issue_dest  [ISSUE_LANES];
    logic [REG_ID_W-1:0] w_commit_rd   [COMMIT_LANES];
    logic [ROB_ID_W-1:0] w_commit_dest [COMMIT_LANES];
    logic [XLEN-1:0]     w_commit_val  [COMMIT_LANES];

    logic [XLEN-1:0]     r_value [REG_NUM];
    logic [REG_NUM-1:0]  r_busy;
    logic [ROB_ID_W-1:0] r_tag   [REG_NUM];

    generate
        for (genvar l = 0; l < ISSUE_LANES; l++) begin : g_issue_unpack
            assign w_issue_rs1[l]  = issue_rs1[l*REG_ID_W +: REG_ID_W];
            assign w_issue_rs2[l]  = issue_rs2[l*REG_ID_W +: REG_ID_W];
            assign w_issue_rd[l]   = issue_rd[l*REG_ID_W +: REG_ID_W];
            assign w_issue_dest[l] = issue_dest[l*ROB_ID_W +: ROB_ID_W];
        end
        for (genvar c = 0; c < COMMIT_LANES; c++) begin : g_commit_unpack
            assign w_commit_rd[c]   = commit_rd[c*REG_ID_W +: REG_ID_W];
            assign w_commit_dest[c] = commit_dest[c*ROB_ID_W +: ROB_ID_W];
            assign w_commit_val[c]  = commit_value[c*XLEN +: XLEN];
        end
    endgenerate

    // Later assignments win: higher commit lanes, then issue over commit clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
        end else if (rdy) begin
            for (int c = 0; c < COMMIT_LANES; c++) begin
                if (commit_valid[c] && (w_commit_rd[c] != '0)) begin
                    r_value[w_commit_rd[c]] <= w_commit_val[c];
                    if (r_busy[w_commit_rd[c]] &&
                        (r_tag[w_commit_rd[c]] == w_commit_dest[c]))
                        r_busy[w_commit_rd[c]] <= 1'b0;
                end
            end
            if (flush) begin
                r_busy <= '0;
            end else begin
                for (int l = 0; l < ISSUE_LANES; l++) begin
                    if (issue_valid[l] && (w_issue_rd[l] != '0)) begin
                        r_busy[w_issue_rd[l]] <= 1'b1;
                        r_tag[w_issue_rd[l]]  <= w_issue_dest[l];
                    end
                end
            end
        end
    end

    generate
        for (genvar l = 0; l < ISSUE_LANES; l++) begin : g_lane
            for (genvar s = 0; s < 2; s++) begin : g_src
                logic [REG_ID_W-1:0] w_src;
                logic                w_issue_hit;
                logic [ROB_ID_W-1:0] w_issue_tag;
                logic                w_commit_hit;
                logic [XLEN-1:0]     w_commit_v;
                logic [XLEN-1:0]     w_v;
                logic [ROB_ID_W-1:0] w_q;
                logic                w_b;

                assign w_src = (s == 0) ? w_issue_rs1[l] : w_issue_rs2[l];

                // Only strictly older lanes forward; a lane never sees its own rd.
                always_comb begin
                    w_issue_hit = 1'b0;
                    w_issue_tag = '0;
                    for (int k = 0; k < l; k++) begin
                        if (issue_valid[k] && (w_issue_rd[k] == w_src)) begin
                            w_issue_hit = 1'b1;
                            w_issue_tag = w_issue_dest[k];
                        end
                    end
                    w_commit_hit = 1'b0;
                    w_commit_v   = '0;
                    for (int c = 0; c < COMMIT_LANES; c++) begin
                        if (commit_valid[c] && (w_commit_rd[c] == w_src) &&
                            (w_commit_dest[c] == r_tag[w_src])) begin
                            w_commit_hit = 1'b1;
                            w_commit_v   = w_commit_val[c];
                        end
                    end
                    w_v = '0;
                    w_q = '0;
                    w_b = 1'b0;
                    if (w_src != '0) begin
                        if (w_issue_hit) begin
                            w_b = 1'b1;
                            w_q = w_issue_tag;
                        end else if (r_busy[w_src] && w_commit_hit) begin
                            w_v = w_commit_v;
                        end else if (r_busy[w_src]) begin
                            w_b = 1'b1;
                            w_q = r_tag[w_src];
                        end else begin
                            w_v = r_value[w_src];
                        end
                    end
                end
            end

            assign vj_out[l*XLEN +: XLEN]         = g_src[0].w_v;
            assign qj_out[l*ROB_ID_W +: ROB_ID_W] = g_src[0].w_q;
            assign qj_busy[l]                     = g_src[0].w_b;
            assign vk_out[l*XLEN +: XLEN]         = g_src[1].w_v;
            assign qk_out[l*ROB_ID_W +: ROB_ID_W] = g_src[1].w_q;
            assign qk_busy[l]                     = g_src[1].w_b;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Brief    : Scoreboard bench for reg_file_mp with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_reg_file_mp;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int TW   = 4;
    localparam int IL   = 2;
    localparam int CL   = 2;

    logic            clk = 1'b0;
    logic            rst, rdy, flush;
    logic [IL-1:0]   issue_valid;
    logic [IL*RW-1:0] issue_rs1, issue_rs2, issue_rd;
    logic [IL*TW-1:0] issue_dest;
    logic [IL*XLEN-1:0] vj_out, vk_out;
    logic [IL*TW-1:0] qj_out, qk_out;
    logic [IL-1:0]   qj_busy, qk_busy;
    logic [CL-1:0]   commit_valid;
    logic [CL*RW-1:0] commit_rd;
    logic [CL*TW-1:0] commit_dest;
    logic [CL*XLEN-1:0] commit_value;

    always #5 clk = ~clk;

    reg_file_mp #(
        .XLEN(XLEN), .REG_NUM(32), .REG_ID_W(RW), .ROB_ID_W(TW),
        .ISSUE_LANES(IL), .COMMIT_LANES(CL)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_dest(issue_dest),
        .vj_out(vj_out), .qj_out(qj_out), .qj_busy(qj_busy),
        .vk_out(vk_out), .qk_out(qk_out), .qk_busy(qk_busy),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_dest(commit_dest), .commit_value(commit_value)
    );

    typedef struct {
        string           name;
        int              lane;
        int              src;
        logic [XLEN-1:0] v;
        logic [TW-1:0]   q;
        logic            b;
    } exp_t;

    exp_t sb[$];
    logic probe = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Monitor: drains every expectation queued for the current cycle.
    always @(negedge clk) begin
        exp_t            e;
        logic [XLEN-1:0] av;
        logic [TW-1:0]   aq;
        logic            ab;
        if (probe) begin
            while (sb.size() > 0) begin
                e  = sb.pop_front();
                av = (e.src == 0) ? vj_out[e.lane*XLEN +: XLEN] : vk_out[e.lane*XLEN +: XLEN];
                aq = (e.src == 0) ? qj_out[e.lane*TW +: TW] : qk_out[e.lane*TW +: TW];
                ab = (e.src == 0) ? qj_busy[e.lane] : qk_busy[e.lane];
                total++;
                if (av !== e.v || aq !== e.q || ab !== e.b) begin
                    bad++;
                    $display("FAIL %s: got v=%h q=%0d busy=%b, want v=%h q=%0d busy=%b",
                             e.name, av, aq, ab, e.v, e.q, e.b);
                end
            end
        end
    end

    task automatic clr();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; probe = 1'b0;
        issue_valid = '0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_dest = '0;
        commit_valid = '0; commit_rd = '0; commit_dest = '0; commit_value = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic src(input int l, input logic [RW-1:0] a, input logic [RW-1:0] b);
        issue_rs1[l*RW +: RW] = a;
        issue_rs2[l*RW +: RW] = b;
    endtask

    task automatic iss(input int l, input logic [RW-1:0] rd, input logic [TW-1:0] d);
        issue_valid[l]         = 1'b1;
        issue_rd[l*RW +: RW]   = rd;
        issue_dest[l*TW +: TW] = d;
    endtask

    task automatic cmt(input int l, input logic [RW-1:0] rd, input logic [TW-1:0] d,
                       input logic [XLEN-1:0] v);
        commit_valid[l]              = 1'b1;
        commit_rd[l*RW +: RW]        = rd;
        commit_dest[l*TW +: TW]      = d;
        commit_value[l*XLEN +: XLEN] = v;
    endtask

    task automatic chk(input string n, input int l, input int s, input logic [XLEN-1:0] v,
                       input logic [TW-1:0] q, input logic b);
        exp_t e;
        e.name = n; e.lane = l; e.src = s; e.v = v; e.q = q; e.b = b;
        sb.push_back(e);
        probe = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr();

        src(0, 5'd5, 5'd0);
        chk("reset_x5", 0, 0, 32'h0, 4'd0, 1'b0);
        chk("x0_read", 0, 1, 32'h0, 4'd0, 1'b0);
        step();

        cmt(0, 5'd5, 4'd3, 32'hDEAD);
        src(0, 5'd5, 5'd0);
        chk("no_bypass_idle", 0, 0, 32'h0, 4'd0, 1'b0);
        step();

        src(0, 5'd5, 5'd0);
        chk("x5_written", 0, 0, 32'hDEAD, 4'd0, 1'b0);
        step();

        iss(0, 5'd7, 4'd0);
        src(1, 5'd7, 5'd0);
        chk("fwd_tag0", 1, 0, 32'h0, 4'd0, 1'b1);
        step();

        cmt(0, 5'd7, 4'd0, 32'h11);
        src(0, 5'd7, 5'd0);
        chk("bypass_tag0", 0, 0, 32'h11, 4'd0, 1'b0);
        step();

        src(0, 5'd7, 5'd0);
        chk("x7_after_commit", 0, 0, 32'h11, 4'd0, 1'b0);
        step();

        iss(0, 5'd3, 4'd4);
        iss(1, 5'd3, 4'd9);
        src(0, 5'd3, 5'd0);
        src(1, 5'd3, 5'd3);
        chk("own_rd_ignored", 0, 0, 32'h0, 4'd0, 1'b0);
        chk("intra_rs1", 1, 0, 32'h0, 4'd4, 1'b1);
        chk("intra_rs2", 1, 1, 32'h0, 4'd4, 1'b1);
        step();

        src(0, 5'd3, 5'd0);
        src(1, 5'd0, 5'd3);
        chk("x3_hi_lane_tag", 0, 0, 32'h0, 4'd9, 1'b1);
        chk("x3_hi_lane_tag_k", 1, 1, 32'h0, 4'd9, 1'b1);
        step();

        iss(0, 5'd8, 4'd2);
        iss(1, 5'd9, 4'd5);
        step();

        cmt(0, 5'd8, 4'd2, 32'h55);
        cmt(1, 5'd9, 4'd1, 32'h77);
        iss(0, 5'd8, 4'd6);
        src(0, 5'd8, 5'd9);
        src(1, 5'd8, 5'd0);
        chk("bypass_x8", 0, 0, 32'h55, 4'd0, 1'b0);
        chk("stale_x9_read", 0, 1, 32'h0, 4'd5, 1'b1);
        chk("fwd_over_bypass", 1, 0, 32'h0, 4'd6, 1'b1);
        step();

        src(0, 5'd8, 5'd9);
        chk("issue_over_clear", 0, 0, 32'h0, 4'd6, 1'b1);
        chk("stale_keeps_busy", 0, 1, 32'h0, 4'd5, 1'b1);
        step();

        iss(0, 5'd4, 4'd1);
        iss(1, 5'd6, 4'd2);
        step();

        flush = 1'b1;
        iss(0, 5'd4, 4'd3);
        cmt(0, 5'd6, 4'd7, 32'h66);
        src(0, 5'd4, 5'd0);
        src(1, 5'd4, 5'd6);
        chk("flush_cyc_x4", 0, 0, 32'h0, 4'd1, 1'b1);
        chk("flush_cyc_fwd", 1, 0, 32'h0, 4'd3, 1'b1);
        chk("flush_cyc_x6", 1, 1, 32'h0, 4'd2, 1'b1);
        step();

        src(0, 5'd4, 5'd6);
        src(1, 5'd8, 5'd9);
        chk("post_flush_x4", 0, 0, 32'h0, 4'd0, 1'b0);
        chk("flush_commit_x6", 0, 1, 32'h66, 4'd0, 1'b0);
        chk("post_flush_x8", 1, 0, 32'h55, 4'd0, 1'b0);
        chk("post_flush_x9", 1, 1, 32'h77, 4'd0, 1'b0);
        step();

        iss(0, 5'd4, 4'd5);
        step();

        rdy = 1'b0;
        flush = 1'b1;
        cmt(0, 5'd4, 4'd5, 32'hAA);
        iss(1, 5'd6, 4'd1);
        step();

        src(0, 5'd4, 5'd6);
        chk("rdy0_x4_held", 0, 0, 32'h0, 4'd5, 1'b1);
        chk("rdy0_x6_held", 0, 1, 32'h66, 4'd0, 1'b0);
        step();

        rst = 1'b1;
        flush = 1'b1;
        iss(0, 5'd5, 4'd2);
        cmt(0, 5'd6, 4'd0, 32'hFF);
        step();

        src(0, 5'd5, 5'd4);
        src(1, 5'd6, 5'd8);
        chk("rst_x5", 0, 0, 32'h0, 4'd0, 1'b0);
        chk("rst_x4", 0, 1, 32'h0, 4'd0, 1'b0);
        chk("rst_x6", 1, 0, 32'h0, 4'd0, 1'b0);
        chk("rst_x8", 1, 1, 32'h0, 4'd0, 1'b0);
        step();
        step();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
